ram_sdp_clr: RTL and testbench

RAM_SDP_CLR -- requirements
Module: ram_sdp_clr

---
 rtl/ram_sdp_clr_pkg.sv | 14 +
 rtl/ram_sdp_core.sv | 41 ++++
 rtl/ram_sdp_clr.sv | 152 +++++++++++++++
 tb/tb_ram_sdp_clr.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_sdp_clr_pkg.sv
// rtl/ram_sdp_clr_pkg.sv - shared types and legal parameter values for the clearable SDP RAM
package ram_sdp_clr_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 2;
  localparam int RDW_OLD    = 0;
  localparam int RDW_MERGE  = 1;

endpackage

// File: rtl/ram_sdp_core.sv
// rtl/ram_sdp_core.sv - plain byte-enable simple-dual-port array with registered read
module ram_sdp_core #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 13
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   waddr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic                re_i,
  input  logic [ADDR_W-1:0]   raddr_i,
  output logic [DATA_W-1:0]   rdata_o
);

  localparam int BE_W = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be_i[i]) mem_q[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
      end
    end
  end

  // Only the output register is reset; array contents are untouched by reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ram_sdp_clr.sv
// rtl/ram_sdp_clr.sv - SDP RAM wrapper with zero-fill FSM, read-during-write bypass and latency pipe
module ram_sdp_clr
  import ram_sdp_clr_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 13,
  parameter int RD_LAT         = 1,
  parameter int RDW_NEW        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [ADDR_W-1:0]   write_address,
  input  logic [DATA_W-1:0]   d,
  input  logic [DATA_W/8-1:0] be,
  input  logic                re,
  input  logic [ADDR_W-1:0]   read_address,
  output logic [DATA_W-1:0]   q,
  output logic                q_valid,
  input  logic                clear_req,
  output logic                busy
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

  state_e            state_q;
  logic              busy_q;
  logic [ADDR_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      busy_q  <= (CLEAR_ON_RESET != 0);
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (clear_req) begin
            state_q <= ST_CLEAR;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        ST_CLEAR: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign busy = busy_q;

  logic              clearing;
  logic              user_we;
  logic              user_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] core_rdata;

  assign clearing  = (state_q == ST_CLEAR);
  assign user_we   = we & ~clearing;
  assign user_re   = re & ~clearing;
  assign mem_we    = clearing | user_we;
  assign mem_waddr = clearing ? cnt_q : write_address;
  assign mem_wdata = clearing ? '0 : d;
  assign mem_be    = clearing ? {BE_W{1'b1}} : be;

  ram_sdp_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .be_i    (mem_be),
    .re_i    (user_re),
    .raddr_i (read_address),
    .rdata_o (core_rdata)
  );

  // The core always returns old data; a same-address write is captured here and merged afterwards.
  logic              byp_hit_d;
  logic              byp_hit_q;
  logic [DATA_W-1:0] byp_data_q;
  logic [BE_W-1:0]   byp_be_q;
  logic              v1_q;
  logic [DATA_W-1:0] merged;

  assign byp_hit_d = (RDW_NEW == RDW_MERGE) && user_we && (write_address == read_address);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byp_hit_q  <= 1'b0;
      byp_data_q <= '0;
      byp_be_q   <= '0;
      v1_q       <= 1'b0;
    end else begin
      v1_q <= user_re;
      if (user_re) begin
        byp_hit_q  <= byp_hit_d;
        byp_data_q <= d;
        byp_be_q   <= be;
      end
    end
  end

  always_comb begin
    merged = core_rdata;
    for (int i = 0; i < BE_W; i++) begin
      if (byp_hit_q && byp_be_q[i]) merged[i*8 +: 8] = byp_data_q[i*8 +: 8];
    end
  end

  if (RD_LAT == RD_LAT_MAX) begin : g_lat2
    logic [DATA_W-1:0] q2_q;
    logic              v2_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        q2_q <= '0;
        v2_q <= 1'b0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) q2_q <= merged;
      end
    end

    assign q       = q2_q;
    assign q_valid = v2_q;
  end else begin : g_lat1
    assign q       = merged;
    assign q_valid = v1_q;
  end

endmodule

// File: tb/tb_ram_sdp_clr.sv
// tb/tb_ram_sdp_clr.sv - two-config bench (lat1/old, lat2/merge) sharing stimulus against a reference model
module tb_ram_sdp_clr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic        clear_req = 1'b0;
  logic [3:0]  wa = '0;
  logic [3:0]  ra = '0;
  logic [15:0] d = '0;
  logic [1:0]  be = '0;

  logic [15:0] q_a, q_b;
  logic        qv_a, qv_b, busy_a, busy_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ram_sdp_clr #(.DATA_W(16), .ADDR_W(4), .RD_LAT(1), .RDW_NEW(0), .CLEAR_ON_RESET(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .we(we), .write_address(wa), .d(d), .be(be),
    .re(re), .read_address(ra), .q(q_a), .q_valid(qv_a), .clear_req(clear_req), .busy(busy_a)
  );

  ram_sdp_clr #(.DATA_W(16), .ADDR_W(4), .RD_LAT(2), .RDW_NEW(1), .CLEAR_ON_RESET(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .we(we), .write_address(wa), .d(d), .be(be),
    .re(re), .read_address(ra), .q(q_b), .q_valid(qv_b), .clear_req(clear_req), .busy(busy_b)
  );

  // Reference model: word array, outstanding fill position and expected visible outputs.
  logic [15:0] mem_m [16];
  int          clr_pos = 0;
  bit          clearing = 1'b1;
  logic [15:0] ea_q = '0, eb_q = '0, b1_d = '0;
  bit          ea_v = 0, eb_v = 0, b1_v = 0;

  task automatic model_edge();
    logic [15:0] old_w, new_w;
    if (!rst_n) begin
      clearing = 1; clr_pos = 0;
      ea_q = '0; ea_v = 0; eb_q = '0; eb_v = 0; b1_d = '0; b1_v = 0;
    end else begin
      eb_v = b1_v;
      if (b1_v) eb_q = b1_d;
      if (clearing) begin
        mem_m[clr_pos] = '0;
        clr_pos++;
        if (clr_pos == 16) clearing = 0;
        ea_v = 0; b1_v = 0;
      end else begin
        if (re) begin
          old_w = mem_m[ra];
          new_w = old_w;
          if (we && wa == ra)
            for (int i = 0; i < 2; i++) if (be[i]) new_w[i*8 +: 8] = d[i*8 +: 8];
          ea_q = old_w; ea_v = 1; b1_d = new_w; b1_v = 1;
        end else begin
          ea_v = 0; b1_v = 0;
        end
        if (we)
          for (int i = 0; i < 2; i++) if (be[i]) mem_m[wa][i*8 +: 8] = d[i*8 +: 8];
        if (clear_req) begin clearing = 1; clr_pos = 0; end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    we = 0; re = 0; clear_req = 0;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 0; idle_inputs();
    step(); step();
    total++;
    if ({busy_a, qv_a, q_a, busy_b, qv_b, q_b} !== {1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0}) begin
      bad++;
      $display("FAIL reset_state got=%b/%b/%h %b/%b/%h want=1/0/0000 1/0/0000",
               busy_a, qv_a, q_a, busy_b, qv_b, q_b);
    end
    rst_n = 1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy_a) break;
      n++;
      step();
    end
    total++;
    if (n != 16 || busy_b !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy_len got=%0d busy_b=%b want=16 busy_b=0", n, busy_b);
    end
  endtask

  task automatic test_clear_zero();
    for (int i = 0; i < 16; i++) begin
      re = 1; ra = 4'(i);
      step();
      total++;
      if ({qv_a, q_a} !== {1'b1, 16'h0000} || {qv_a, q_a} !== {ea_v, ea_q}) begin
        bad++;
        $display("FAIL clear_zero_a addr=%0d got=%b/%h want=1/0000", i, qv_a, q_a);
      end
      total++;
      if ({qv_b, q_b} !== {eb_v, eb_q} || (i > 0 && q_b !== 16'h0000)) begin
        bad++;
        $display("FAIL clear_zero_b addr=%0d got=%b/%h want=%b/%h", i, qv_b, q_b, eb_v, eb_q);
      end
    end
    idle_inputs(); step(); step();
  endtask

  task automatic test_byte_enable();
    we = 1; wa = 5; d = 16'hBEEF; be = 2'b11; step();
    d = 16'h1234; be = 2'b01; step();
    we = 0; re = 1; ra = 5; step();
    total++;
    if ({qv_a, q_a} !== {1'b1, 16'hBE34}) begin
      bad++;
      $display("FAIL be_merge_a got=%b/%h want=1/be34", qv_a, q_a);
    end
    re = 0; step();
    total++;
    if ({qv_b, q_b, qv_a, q_a} !== {1'b1, 16'hBE34, 1'b0, 16'hBE34}) begin
      bad++;
      $display("FAIL be_merge_b got=%b/%h a_hold=%b/%h want=1/be34 0/be34", qv_b, q_b, qv_a, q_a);
    end
    step();
  endtask

  task automatic test_rdw();
    we = 1; re = 1; wa = 7; ra = 7; d = 16'hAAAA; be = 2'b11; step();
    total++;
    if ({qv_a, q_a} !== {1'b1, 16'h0000}) begin
      bad++;
      $display("FAIL rdw_old got=%b/%h want=1/0000", qv_a, q_a);
    end
    idle_inputs(); step();
    total++;
    if ({qv_b, q_b} !== {1'b1, 16'hAAAA}) begin
      bad++;
      $display("FAIL rdw_new got=%b/%h want=1/aaaa", qv_b, q_b);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [4];
    for (int i = 0; i < 4; i++) begin
      vals[i] = 16'h1000 + 16'(i * 16'h0111);
      we = 1; wa = 4'(i); d = vals[i]; be = 2'b11; step();
    end
    we = 0;
    for (int s = 0; s < 7; s++) begin
      re = (s < 4); ra = 4'(s);
      step();
      total++;
      if (qv_b !== (s >= 1 && s <= 4) || (s >= 1 && s <= 4 && q_b !== vals[s-1])) begin
        bad++;
        $display("FAIL b2b_lat2 sample=%0d got=%b/%h", s, qv_b, q_b);
      end
      total++;
      if (qv_a !== (s <= 3) || (s <= 3 && q_a !== vals[s])) begin
        bad++;
        $display("FAIL b2b_lat1 sample=%0d got=%b/%h", s, qv_a, q_a);
      end
    end
    idle_inputs();
  endtask

  task automatic test_clear_req();
    int n;
    clear_req = 1; step();
    clear_req = 0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy_a) break;
      we = (i == 0); wa = 3; d = 16'h5555; be = 2'b11; re = (i == 1); ra = 3;
      n++;
      step();
      total++;
      if ({busy_a, qv_a, qv_b} !== {clearing, ea_v, eb_v}) begin
        bad++;
        $display("FAIL clear_busy i=%0d got=%b/%b/%b want=%b/%b/%b",
                 i, busy_a, qv_a, qv_b, clearing, ea_v, eb_v);
      end
    end
    idle_inputs();
    total++;
    if (n != 16) begin
      bad++;
      $display("FAIL clear_len got=%0d want=16", n);
    end
    re = 1; ra = 3; step(); re = 0; step();
    total++;
    if ({qv_b, q_b, q_a} !== {1'b1, 16'h0000, 16'h0000}) begin
      bad++;
      $display("FAIL clear_ignored_write got=%b/%h/%h want=1/0000/0000", qv_b, q_b, q_a);
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    clear_req = 1; step();
    clear_req = 0;
    for (int i = 0; i < 9; i++) step();
    rst_n = 0; step();
    rst_n = 1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy_a) break;
      n++;
      step();
    end
    total++;
    if (n != 16) begin
      bad++;
      $display("FAIL reset_mid_clear_len got=%0d want=16", n);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      we = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      wa = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
      d = 16'($urandom);
      be = 2'($urandom_range(0, 3));
      clear_req = ($urandom_range(0, 79) == 0);
      step();
      total++;
      if ({busy_a, qv_a, q_a} !== {clearing, ea_v, ea_q}) begin
        bad++;
        $display("FAIL rand_a cyc=%0d got=%b/%b/%h want=%b/%b/%h",
                 c, busy_a, qv_a, q_a, clearing, ea_v, ea_q);
      end
      total++;
      if ({busy_b, qv_b, q_b} !== {clearing, eb_v, eb_q}) begin
        bad++;
        $display("FAIL rand_b cyc=%0d got=%b/%b/%h want=%b/%b/%h",
                 c, busy_b, qv_b, q_b, clearing, eb_v, eb_q);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_clear_zero();
    test_byte_enable();
    test_rdw();
    test_back_to_back();
    test_clear_req();
    test_reset_mid_clear();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
